ddr_mport_arb: RTL and testbench

- Parametrised N-channel front-end that shares one DDR burst port (wr_req/rd_req/cmd_addr/data_in/avl_be/bst_len/ddr_rdy/ddr_vld/data_out) between NCH client channels.
- Round-robin arbitration; write bursts lock the port until their last beat.
- Reads are pipelined: up to RD_OUTS commands may be outstanding, and return beats are routed in order to the issuing channel.
- Sits between the CNN layer DMA engines and the DDR controller/model.

---
 rtl/ddr_arb_pkg.sv | 26 ++
 rtl/ddr_tag_fifo.sv | 58 +++++
 rtl/ddr_mport_arb.sv | 193 +++++++++++++++++++
 tb/tb_ddr_mport_arb.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types for the multi-port DDR front-end.
// Read tags and FSM encodings used by the arbiter and its tag FIFO.
package ddr_arb_pkg;

  localparam int DDR_AW  = 26;
  localparam int DDR_DW  = 512;
  localparam int DDR_LW  = 7;
  // Tag id is sized for the largest supported channel count (16).
  localparam int TAG_IDW = 4;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef enum logic {
    OP_WR,
    OP_RD
  } op_t;

  typedef struct packed {
    logic [TAG_IDW-1:0] id;
    logic [DDR_LW-1:0]  len;
  } rd_tag_t;

endpackage

// File: rtl/ddr_tag_fifo.sv
// In-order FIFO of outstanding read tags.
// Head is the tag whose return beats are arriving now.
module ddr_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  rd_tag_t       din,
  input  logic          pop,
  output rd_tag_t       head,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count
);

  rd_tag_t       mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign head  = mem[rp];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        wp <= wp + 1'b1;
      end
      if (rd_en) begin
        rp <= rp + 1'b1;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ddr_mport_arb.sv
// Round-robin front-end sharing one DDR burst port among NCH clients.
// Writes lock the port for the whole burst; reads are tagged and routed back in order.
module ddr_mport_arb
  import ddr_arb_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int AW      = DDR_AW,
  parameter int DW      = DDR_DW,
  parameter int BW      = DW/8,
  parameter int LW      = DDR_LW,
  parameter int RD_OUTS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_wr_req,
  input  logic [NCH-1:0]    ch_rd_req,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  input  logic [NCH*BW-1:0] ch_be,
  input  logic [NCH*LW-1:0] ch_bst_len,
  output logic [NCH-1:0]    ch_rdy,
  output logic [NCH-1:0]    ch_rvld,
  output logic [DW-1:0]     ch_rdata,
  output logic              wr_req,
  output logic              rd_req,
  output logic [AW-1:0]     cmd_addr,
  output logic [DW-1:0]     data_in,
  output logic [BW-1:0]     avl_be,
  output logic [LW-1:0]     bst_len,
  input  logic [DW-1:0]     data_out,
  input  logic              ddr_rdy,
  input  logic              ddr_vld,
  output logic              rd_err
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(RD_OUTS) + 1;

  state_t          state;
  op_t             op;
  logic [IW-1:0]   gnt_id;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   nxt_id;
  logic [IW-1:0]   win_id;
  logic            win_vld;
  logic [LW-1:0]   win_len;
  logic [LW-1:0]   cur_len;
  logic [LW-1:0]   wbeat;
  logic [LW-1:0]   rbeat;
  logic [NCH-1:0]  rd_ok;
  logic [NCH-1:0]  cand;
  logic            req_sel;
  logic            acc;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            rd_hit;
  logic [CW-1:0]   count;
  rd_tag_t         push_tag;
  rd_tag_t         head;

  // Reads are withheld from arbitration once every tag slot is in use.
  assign rd_ok = (count == CW'(RD_OUTS)) ? '0 : ch_rd_req;
  assign cand  = ch_wr_req | rd_ok;

  always_comb begin
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = 0; i < NCH; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NCH) begin
        j = j - NCH;
      end
      if (!win_vld && cand[j]) begin
        win_vld = 1'b1;
        win_id  = IW'(j);
      end
    end
    win_len = ch_bst_len[int'(win_id)*LW +: LW];
  end

  assign nxt_id = (gnt_id == IW'(NCH-1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    cmd_addr = '0;
    data_in  = '0;
    avl_be   = '0;
    bst_len  = '0;
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    ch_rdy   = '0;
    req_sel  = 1'b0;
    if (state == BUSY) begin
      cmd_addr       = ch_addr[int'(gnt_id)*AW +: AW];
      data_in        = ch_wdata[int'(gnt_id)*DW +: DW];
      avl_be         = ch_be[int'(gnt_id)*BW +: BW];
      bst_len        = cur_len;
      wr_req         = (op == OP_WR) & ch_wr_req[gnt_id];
      rd_req         = (op == OP_RD) & ch_rd_req[gnt_id];
      req_sel        = wr_req | rd_req;
      ch_rdy[gnt_id] = ddr_rdy;
    end
  end

  assign acc  = req_sel & ddr_rdy;
  assign push = acc & (op == OP_RD) & ~full;

  always_comb begin
    push_tag     = '0;
    push_tag.id  = TAG_IDW'(gnt_id);
    push_tag.len = DDR_LW'(cur_len);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      op      <= OP_WR;
      gnt_id  <= '0;
      rr_ptr  <= '0;
      cur_len <= '0;
      wbeat   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            gnt_id  <= win_id;
            op      <= ch_wr_req[win_id] ? OP_WR : OP_RD;
            cur_len <= (win_len == '0) ? LW'(1) : win_len;
            wbeat   <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (acc) begin
            if (op == OP_RD || wbeat == cur_len - 1'b1) begin
              state  <= IDLE;
              wbeat  <= '0;
              rr_ptr <= nxt_id;
            end else begin
              wbeat <= wbeat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return path runs independently of the command FSM.
  assign rd_hit   = ddr_vld & ~empty;
  assign pop      = rd_hit & (rbeat == LW'(head.len) - 1'b1);
  assign ch_rvld  = rd_hit ? (NCH'(1) << head.id) : '0;
  assign ch_rdata = data_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rbeat  <= '0;
      rd_err <= 1'b0;
    end else begin
      if (rd_hit) begin
        rbeat <= pop ? '0 : rbeat + 1'b1;
      end
      if (ddr_vld && empty) begin
        rd_err <= 1'b1;
      end
    end
  end

  ddr_tag_fifo #(
    .DEPTH (RD_OUTS)
  ) u_tags (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_tag),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always @(posedge clk) begin
    if (rst_n && state == BUSY) begin
      assert (req_sel)
        else $error("ddr_mport_arb: client dropped request mid-command");
    end
  end

endmodule

// File: tb/tb_ddr_mport_arb.sv
// Directed bench for ddr_mport_arb with a queue-based scoreboard.
// Stimulus pushes expected DDR commands and read returns; a monitor pops and compares.
module tb_ddr_mport_arb;

  localparam int NCH     = 4;
  localparam int AW      = 26;
  localparam int DW      = 64;
  localparam int BW      = 8;
  localparam int LW      = 7;
  localparam int RD_OUTS = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    ch_wr_req;
  logic [NCH-1:0]    ch_rd_req;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_wdata;
  logic [NCH*BW-1:0] ch_be;
  logic [NCH*LW-1:0] ch_bst_len;
  logic [NCH-1:0]    ch_rdy;
  logic [NCH-1:0]    ch_rvld;
  logic [DW-1:0]     ch_rdata;
  logic              wr_req;
  logic              rd_req;
  logic [AW-1:0]     cmd_addr;
  logic [DW-1:0]     data_in;
  logic [BW-1:0]     avl_be;
  logic [LW-1:0]     bst_len;
  logic [DW-1:0]     data_out;
  logic              ddr_rdy;
  logic              ddr_vld;
  logic              rd_err;

  ddr_mport_arb #(
    .NCH(NCH), .AW(AW), .DW(DW), .BW(BW), .LW(LW), .RD_OUTS(RD_OUTS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_wr_req(ch_wr_req), .ch_rd_req(ch_rd_req),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_be(ch_be),
    .ch_bst_len(ch_bst_len), .ch_rdy(ch_rdy), .ch_rvld(ch_rvld),
    .ch_rdata(ch_rdata), .wr_req(wr_req), .rd_req(rd_req),
    .cmd_addr(cmd_addr), .data_in(data_in), .avl_be(avl_be),
    .bst_len(bst_len), .data_out(data_out), .ddr_rdy(ddr_rdy),
    .ddr_vld(ddr_vld), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           wr;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  len;
    logic [NCH-1:0] rdy;
    logic [DW-1:0]  data;
    logic [BW-1:0]  be;
  } cmd_t;

  typedef struct {
    logic [NCH-1:0] vld;
    logic [DW-1:0]  data;
  } ret_t;

  cmd_t exp_cmd[$];
  ret_t exp_ret[$];
  cmd_t me;
  ret_t mr;
  int   checks = 0;
  int   errors = 0;
  int   rd_pend[NCH];
  logic wr_on;
  int   wr_ch;
  int   wr_n;
  int   wr_k;
  int   ret_seq;

  function automatic logic [AW-1:0] addr_of(int ch);
    return AW'(32'h0010_0000 * (ch + 1) + 32'h40);
  endfunction

  function automatic logic [DW-1:0] wdat(int ch, int k);
    return {32'hC0DE_0000 | 32'(ch), 32'h0000_1000 + 32'(k)};
  endfunction

  function automatic logic [BW-1:0] bep(int k);
    return BW'(8'h81 ^ 8'(k * 3));
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic exp_wr(int ch, int n, int len);
    cmd_t c;
    for (int k = 0; k < n; k++) begin
      c.wr   = 1'b1;
      c.addr = addr_of(ch);
      c.len  = LW'(len);
      c.rdy  = NCH'(1) << ch;
      c.data = wdat(ch, k);
      c.be   = bep(k);
      exp_cmd.push_back(c);
    end
  endtask

  task automatic exp_rd(int ch, int len);
    cmd_t c;
    c.wr   = 1'b0;
    c.addr = addr_of(ch);
    c.len  = LW'(len);
    c.rdy  = NCH'(1) << ch;
    c.data = '0;
    c.be   = '0;
    exp_cmd.push_back(c);
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      ch_rd_req[i] = (rd_pend[i] > 0);
      ch_wr_req[i] = wr_on && (i == wr_ch);
    end
    ch_wdata[wr_ch*DW +: DW] = wdat(wr_ch, wr_k);
    ch_be[wr_ch*BW +: BW]    = bep(wr_k);
  endtask

  task automatic tick();
    logic [NCH-1:0] racc;
    logic           wacc;
    @(negedge clk);
    racc = (rd_req && ddr_rdy) ? ch_rdy : '0;
    wacc = wr_req && ddr_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (racc[i] && rd_pend[i] > 0) rd_pend[i]--;
    end
    if (wacc) wr_k++;
    if (wr_on && wr_k >= wr_n) wr_on = 1'b0;
    drive();
  endtask

  function automatic bit busy();
    bit b;
    b = wr_on;
    for (int i = 0; i < NCH; i++) begin
      if (rd_pend[i] > 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic run_idle(string nm, int max);
    int t;
    t = 0;
    while (busy() && t < max) begin
      tick();
      t++;
    end
    if (busy()) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, want idle", nm, t);
    end
  endtask

  task automatic set_len(int ch, int n);
    ch_bst_len[ch*LW +: LW] = LW'(n);
  endtask

  task automatic start_wr(int ch, int n);
    set_len(ch, n);
    wr_on = 1'b1;
    wr_ch = ch;
    wr_n  = n;
    wr_k  = 0;
    drive();
  endtask

  task automatic ret(int ch, int n);
    ret_t r;
    for (int k = 0; k < n; k++) begin
      ret_seq++;
      r.vld    = NCH'(1) << ch;
      r.data   = 64'hD00D_0000_0000_0000 + DW'(ret_seq);
      exp_ret.push_back(r);
      ddr_vld  = 1'b1;
      data_out = r.data;
      tick();
    end
    ddr_vld  = 1'b0;
    data_out = '0;
  endtask

  task automatic do_reset();
    wr_on = 1'b0;
    for (int i = 0; i < NCH; i++) rd_pend[i] = 0;
    drive();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compares DDR command beats and read returns.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ddr_rdy && (wr_req || rd_req)) begin
        if (exp_cmd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexp: got addr %h rdy %b, want no command",
                   cmd_addr, ch_rdy);
        end else begin
          me = exp_cmd.pop_front();
          chk("cmd", {wr_req, rd_req, cmd_addr, bst_len, ch_rdy},
              {me.wr, !me.wr, me.addr, me.len, me.rdy});
          if (me.wr) begin
            chk("wbeat", {data_in, avl_be}, {me.data, me.be});
          end
        end
      end else if (ch_rdy != '0) begin
        checks++;
        errors++;
        $display("FAIL rdy_stray: got ch_rdy %b, want 0", ch_rdy);
      end
      if (ch_rvld != '0) begin
        if (exp_ret.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ret_unexp: got ch_rvld %b, want 0", ch_rvld);
        end else begin
          mr = exp_ret.pop_front();
          chk("ret", {ch_rvld, ch_rdata}, {mr.vld, mr.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int st;
    int t;
    rst_n      = 1'b0;
    ch_wr_req  = '0;
    ch_rd_req  = '0;
    ch_wdata   = '0;
    ch_be      = '0;
    ch_bst_len = '0;
    ddr_rdy    = 1'b1;
    ddr_vld    = 1'b0;
    data_out   = '0;
    wr_on      = 1'b0;
    wr_ch      = 0;
    wr_n       = 0;
    wr_k       = 0;
    ret_seq    = 0;
    for (int i = 0; i < NCH; i++) begin
      ch_addr[i*AW +: AW] = addr_of(i);
      rd_pend[i] = 0;
    end
    do_reset();
    @(negedge clk);
    chk("reset_outs",
        {ch_rdy, ch_rvld, wr_req, rd_req, cmd_addr, data_in, avl_be, bst_len, rd_err},
        '0);
    @(posedge clk);
    #1;

    // Channel 2 write, 4 beats, beat 2 stalled for 3 cycles.
    exp_wr(2, 4, 4);
    start_wr(2, 4);
    st = 0;
    t  = 0;
    while (wr_on && t < 50) begin
      if (wr_k == 2 && st < 3) begin
        ddr_rdy = 1'b0;
        st++;
      end else begin
        ddr_rdy = 1'b1;
      end
      tick();
      t++;
    end
    ddr_rdy = 1'b1;
    chk("wr_done", {31'd0, wr_on}, '0);
    chk("wr_beats_left", 128'(exp_cmd.size()), '0);

    // Pointer now 3: simultaneous reads from 0 and 3 serve 3 first.
    set_len(0, 1);
    set_len(3, 1);
    exp_rd(3, 1);
    exp_rd(0, 1);
    rd_pend[0] = 1;
    rd_pend[3] = 1;
    drive();
    run_idle("ptr", 20);
    ret(3, 1);
    ret(0, 1);

    // Round robin: all channels hold read requests, 8 commands of len 2.
    do_reset();
    for (int i = 0; i < NCH; i++) set_len(i, 2);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NCH; i++) exp_rd(i, 2);
    end
    for (int i = 0; i < NCH; i++) rd_pend[i] = 2;
    drive();
    t = 0;
    while (busy() && t < 100) begin
      tick();
      t++;
    end
    chk("rr_cycles", 128'(t), 128'(16));

    // Tag FIFO full: ninth read held back while a write on channel 1 goes.
    exp_wr(1, 2, 2);
    rd_pend[3] = 1;
    start_wr(1, 2);
    t = 0;
    while (wr_on && t < 20) begin
      tick();
      t++;
    end
    for (int k = 0; k < 4; k++) tick();
    chk("rd_masked", 128'(rd_pend[3]), 128'(1));
    chk("wr_under_full", 128'(exp_cmd.size()), '0);
    exp_rd(3, 2);
    ret(0, 2);
    run_idle("rd9", 20);
    ret(1, 2);
    ret(2, 2);
    ret(3, 2);
    ret(0, 2);
    ret(1, 2);
    ret(2, 2);
    ret(3, 2);
    ret(3, 2);

    // Back-to-back returns: ch0 len 3, then ch3 len 1.
    do_reset();
    set_len(0, 3);
    set_len(3, 1);
    exp_rd(0, 3);
    exp_rd(3, 1);
    rd_pend[0] = 1;
    rd_pend[3] = 1;
    drive();
    run_idle("b2b", 20);
    ret(0, 3);
    ret(3, 1);

    // Reset during beat 5 of a 16-beat write, with a read tag outstanding.
    do_reset();
    set_len(2, 1);
    exp_rd(2, 1);
    rd_pend[2] = 1;
    drive();
    run_idle("pre_rd", 20);
    exp_wr(1, 5, 16);
    start_wr(1, 16);
    t = 0;
    while (wr_k < 5 && t < 40) begin
      tick();
      t++;
    end
    rst_n = 1'b0;
    wr_on = 1'b0;
    drive();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_outs",
        {ch_rdy, ch_rvld, wr_req, rd_req, cmd_addr, data_in, avl_be, bst_len, rd_err},
        '0);
    chk("midrst_beats", 128'(exp_cmd.size()), '0);
    @(posedge clk);
    #1;

    // Discarded tag: a return beat now hits an empty FIFO.
    ddr_vld  = 1'b1;
    data_out = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    chk("err_no_rvld", 128'(ch_rvld), '0);
    @(posedge clk);
    #1;
    ddr_vld  = 1'b0;
    data_out = '0;
    @(negedge clk);
    chk("rd_err_set", 128'(rd_err), 128'(1));
    @(posedge clk);
    #1;

    // Service resumes normally after reset.
    set_len(0, 1);
    exp_rd(0, 1);
    rd_pend[0] = 1;
    drive();
    run_idle("post_rd", 20);
    ret(0, 1);
    exp_wr(1, 2, 2);
    start_wr(1, 2);
    run_idle("post_wr", 20);
    for (int k = 0; k < 3; k++) tick();
    chk("rd_err_sticky", 128'(rd_err), 128'(1));
    chk("sb_cmd_drain", 128'(exp_cmd.size()), '0);
    chk("sb_ret_drain", 128'(exp_ret.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
